// File: rtl/exc_ctrl.sv
// CP0 exception controller: SR/Cause/EPC/PRId, exception and interrupt take, eret, flush sequencing.
// Optional macro EXC_CTRL_COUNT_EN adds CP0 register 22, a wrapping count of taken exceptions/interrupts.
module exc_ctrl #(
  parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL     = 32'h2019_1217,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  exc_in,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic        eret_m,
  input  logic [5:0]  hw_int,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        exl
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;
  localparam logic [4:0] ADDR_COUNT = 5'd22;
  localparam logic [7:0] CNT_INIT   = 8'(FLUSH_CYCLES - 1);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t      state, state_next;
  logic [7:0]  cnt, cnt_next;
  logic [5:0]  sr_im;
  logic        sr_exl, sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_code;
  logic [31:0] epc;
  logic [31:0] epc_raw;
  logic        int_req, exc_req;
  logic        take, do_eret, do_wr;

  assign int_req = (|(cause_ip & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = (exc_in != 5'd0) & ~sr_exl;
  assign epc_raw = bd_m ? (pc_m - 32'd4) : pc_m;
  assign exl     = sr_exl;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_RUN;
      cnt        <= '0;
      sr_im      <= '0;
      sr_exl     <= 1'b0;
      sr_ie      <= 1'b0;
      cause_bd   <= 1'b0;
      cause_ip   <= '0;
      cause_code <= '0;
      epc        <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      cause_ip <= hw_int;
      if (take) begin
        sr_exl     <= 1'b1;
        cause_bd   <= bd_m;
        cause_code <= int_req ? 5'd0 : exc_in;
        epc        <= {epc_raw[31:2], 2'b00};
      end else if (do_eret) begin
        sr_exl <= 1'b0;
      end else if (do_wr) begin
        if (cp0_addr == ADDR_SR) begin
          sr_im  <= cp0_wdata[15:10];
          sr_exl <= cp0_wdata[1];
          sr_ie  <= cp0_wdata[0];
        end else if (cp0_addr == ADDR_EPC) begin
          epc <= cp0_wdata;
        end
      end
    end
  end

  // A take outranks eret and mtc0 in the same cycle; nothing is accepted while flushing.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    take        = 1'b0;
    do_eret     = 1'b0;
    do_wr       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    flush       = 1'b0;
    case (state)
      ST_RUN: begin
        if (int_req || exc_req) begin
          take        = 1'b1;
          redirect    = 1'b1;
          redirect_pc = HANDLER_PC;
          flush       = 1'b1;
          state_next  = ST_FLUSH;
          cnt_next    = CNT_INIT;
        end else if (eret_m) begin
          do_eret     = 1'b1;
          redirect    = 1'b1;
          redirect_pc = epc;
          flush       = 1'b1;
        end else if (cp0_we) begin
          do_wr = 1'b1;
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
        if (cnt == 8'd0) begin
          state_next = ST_RUN;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      default: begin
        state_next = ST_RUN;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef EXC_CTRL_COUNT_EN
  logic [31:0] take_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      take_count <= '0;
    end else if (take) begin
      take_count <= take_count + 32'd1;
    end else if (do_wr && cp0_addr == ADDR_COUNT) begin
      take_count <= cp0_wdata;
    end
  end
`endif

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_SR:    cp0_rdata = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
      ADDR_CAUSE: cp0_rdata = {cause_bd, 15'd0, cause_ip, 3'd0, cause_code, 2'd0};
      ADDR_EPC:   cp0_rdata = epc;
      ADDR_PRID:  cp0_rdata = PRID_VAL;
`ifdef EXC_CTRL_COUNT_EN
      ADDR_COUNT: cp0_rdata = take_count;
`endif
      default:    cp0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed vector table, count sequence, then random stimulus
// compared against a register-level behavioural model of CP0.
module tb_exc_ctrl;

  localparam logic [31:0] HANDLER = 32'h0000_4180;
  localparam logic [31:0] PRID    = 32'h2019_1217;
  localparam int          NFLUSH  = 2;
`ifdef EXC_CTRL_COUNT_EN
  localparam bit          COUNT_EN = 1'b1;
`else
  localparam bit          COUNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  exc_in;
  logic [31:0] pc_m;
  logic        bd_m;
  logic        eret_m;
  logic [5:0]  hw_int;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        exl;

  int checks = 0;
  int errors = 0;

  exc_ctrl #(.HANDLER_PC(HANDLER), .PRID_VAL(PRID), .FLUSH_CYCLES(NFLUSH)) dut (
    .clk(clk), .reset(reset), .exc_in(exc_in), .pc_m(pc_m), .bd_m(bd_m), .eret_m(eret_m),
    .hw_int(hw_int), .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
    .cp0_rdata(cp0_rdata), .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush), .exl(exl)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_n;
    logic [4:0]  exc;
    logic [31:0] pc;
    bit          bd;
    bit          eret;
    logic [5:0]  hw;
    bit          we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    bit          e_redir;
    logic [31:0] e_rpc;
    bit          e_flush;
    bit          e_exl;
    logic [31:0] e_rdata;
  } vec_t;

  // Behavioural CP0 model: plain registers plus a count of remaining flush cycles.
  logic [5:0]  m_im, m_ip;
  logic        m_ie, m_exl, m_bd;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_count;
  int          m_flush_left;

  function automatic vec_t mk(int r, int ex, logic [31:0] pc, int bd, int er, int hw, int we, int addr,
                              logic [31:0] wd, int rd, logic [31:0] rpc, int fl, int ex_l, logic [31:0] rdata);
    vec_t v;
    v.rst_n = r[0];  v.exc = 5'(ex); v.pc = pc; v.bd = bd[0]; v.eret = er[0]; v.hw = 6'(hw);
    v.we = we[0];    v.addr = 5'(addr); v.wdata = wd;
    v.e_redir = rd[0]; v.e_rpc = rpc; v.e_flush = fl[0]; v.e_exl = ex_l[0]; v.e_rdata = rdata;
    return v;
  endfunction

  function automatic logic [31:0] modelRead(logic [4:0] a);
    case (a)
      5'd12:   return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13:   return (32'(m_bd) << 31) | (32'(m_ip) << 10) | (32'(m_code) << 2);
      5'd14:   return m_epc;
      5'd15:   return PRID;
      5'd22:   return COUNT_EN ? m_count : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit modelIntReq();
    return ((m_ip & m_im) != 6'd0) && m_ie && !m_exl;
  endfunction

  function automatic bit modelTake(vec_t v);
    if (m_flush_left > 0) return 1'b0;
    return modelIntReq() || (v.exc != 5'd0 && !m_exl);
  endfunction

  function automatic vec_t modelPredict(vec_t v);
    vec_t p = v;
    bit   tk = modelTake(v);
    bit   er = (m_flush_left == 0) && !tk && v.eret;
    p.e_redir = tk || er;
    p.e_rpc   = tk ? HANDLER : (er ? m_epc : 32'd0);
    p.e_flush = (m_flush_left > 0) || tk || er;
    p.e_exl   = m_exl;
    p.e_rdata = modelRead(v.addr);
    return p;
  endfunction

  task automatic modelAdvance(vec_t v);
    bit tk = modelTake(v);
    if (!v.rst_n) begin
      m_im = '0; m_ip = '0; m_ie = 0; m_exl = 0; m_bd = 0; m_code = '0;
      m_epc = '0; m_count = '0; m_flush_left = 0;
      return;
    end
    if (tk) begin
      m_code  = modelIntReq() ? 5'd0 : v.exc;
      m_exl   = 1'b1;
      m_bd    = v.bd;
      m_epc   = (v.bd ? v.pc - 32'd4 : v.pc) & ~32'd3;
      m_count = m_count + 32'd1;
      m_flush_left = NFLUSH;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (v.eret) begin
      m_exl = 1'b0;
    end else if (v.we) begin
      if (v.addr == 5'd12) begin
        m_im = v.wdata[15:10]; m_exl = v.wdata[1]; m_ie = v.wdata[0];
      end else if (v.addr == 5'd14) begin
        m_epc = v.wdata;
      end else if (v.addr == 5'd22 && COUNT_EN) begin
        m_count = v.wdata;
      end
    end
    m_ip = v.hw;
  endtask

  task automatic applyStimulus(vec_t v);
    reset = v.rst_n; exc_in = v.exc; pc_m = v.pc; bd_m = v.bd; eret_m = v.eret;
    hw_int = v.hw; cp0_we = v.we; cp0_addr = v.addr; cp0_wdata = v.wdata;
  endtask

  task automatic cmp(string tag, string what, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s %s: got 0x%08h, expected 0x%08h", tag, what, act, req);
    end
  endtask

  task automatic checkOutput(string tag, vec_t e);
    cmp(tag, "redirect", 32'(redirect), 32'(e.e_redir));
    cmp(tag, "redirect_pc", redirect_pc, e.e_rpc);
    cmp(tag, "flush", 32'(flush), 32'(e.e_flush));
    cmp(tag, "exl", 32'(exl), 32'(e.e_exl));
    cmp(tag, "cp0_rdata", cp0_rdata, e.e_rdata);
  endtask

  // One cycle: drive after the falling edge, check mid-low-phase, update model at the rising edge.
  task automatic runCycle(vec_t v, bit from_table, string tag);
    applyStimulus(v);
    #2;
    if (from_table) checkOutput(tag, v);
    else            checkOutput(tag, modelPredict(v));
    @(posedge clk);
    modelAdvance(v);
    @(negedge clk);
  endtask

  function automatic vec_t idle(int addr);
    return mk(1, 0, 0, 0, 0, 0, 0, addr, 0, 0, 0, 0, 0, 0);
  endfunction

  vec_t table_v[$];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    logic [4:0] exc_pool [5] = '{5'd4, 5'd5, 5'd8, 5'd10, 5'd12};
    logic [4:0] addr_pool[6] = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd22, 5'd3};
    logic [31:0] exp_count;

    m_im = '0; m_ip = '0; m_ie = 0; m_exl = 0; m_bd = 0; m_code = '0;
    m_epc = '0; m_count = '0; m_flush_left = 0;

    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);

    //            rst exc pc        bd er hw we ad wdata     redir rpc      fl exl rdata
    table_v.push_back(mk(0, 0, 0,        0, 0, 0, 0, 12, 0,        0, 0,       0, 0, 0));
    table_v.push_back(mk(1, 0, 0,        0, 0, 0, 0, 15, 0,        0, 0,       0, 0, PRID));
    table_v.push_back(mk(1, 0, 0,        0, 0, 0, 1, 12, 'h401,    0, 0,       0, 0, 0));
    table_v.push_back(mk(1, 0, 0,        0, 0, 1, 0, 12, 0,        0, 0,       0, 0, 'h401));
    table_v.push_back(mk(1, 0, 'h1000,   0, 0, 1, 0, 13, 0,        1, HANDLER, 1, 0, 'h400));
    table_v.push_back(mk(1, 0, 0,        0, 0, 0, 0, 13, 0,        0, 0,       1, 1, 'h400));
    table_v.push_back(mk(1, 0, 0,        0, 0, 0, 0, 14, 0,        0, 0,       1, 1, 'h1000));
    table_v.push_back(mk(1, 4, 'h2222,   0, 0, 0, 0, 13, 0,        0, 0,       0, 1, 0));
    table_v.push_back(mk(1, 0, 0,        0, 1, 0, 0, 13, 0,        1, 'h1000,  1, 1, 0));
    table_v.push_back(mk(1, 0, 0,        0, 0, 0, 0, 12, 0,        0, 0,       0, 0, 'h401));
    table_v.push_back(mk(1, 10, 'h3010,  1, 0, 0, 0, 14, 0,        1, HANDLER, 1, 0, 'h1000));
    table_v.push_back(mk(1, 0, 0,        0, 0, 0, 0, 13, 0,        0, 0,       1, 1, 'h8000_0028));
    table_v.push_back(mk(1, 0, 0,        0, 0, 0, 0, 14, 0,        0, 0,       1, 1, 'h300C));
    table_v.push_back(mk(1, 0, 0,        0, 0, 0, 1, 14, 'h3020,   0, 0,       0, 1, 'h300C));
    table_v.push_back(mk(1, 0, 0,        0, 1, 0, 0, 14, 0,        1, 'h3020,  1, 1, 'h3020));
    table_v.push_back(mk(1, 0, 0,        0, 0, 0, 0, 12, 0,        0, 0,       0, 0, 'h401));
    table_v.push_back(mk(1, 0, 0,        0, 0, 1, 0, 13, 0,        0, 0,       0, 0, 'h8000_0028));
    table_v.push_back(mk(1, 4, 'h2000,   0, 0, 1, 0, 13, 0,        1, HANDLER, 1, 0, 'h8000_0428));
    table_v.push_back(mk(1, 0, 0,        0, 0, 0, 0, 13, 0,        0, 0,       1, 1, 'h400));
    table_v.push_back(mk(1, 0, 0,        0, 0, 0, 0, 14, 0,        0, 0,       1, 1, 'h2000));
    table_v.push_back(mk(1, 0, 0,        0, 0, 0, 1, 12, 'h1,      0, 0,       0, 1, 'h403));
    table_v.push_back(mk(1, 12, 'h6004,  0, 0, 0, 1, 14, 'h5000,   1, HANDLER, 1, 0, 'h2000));
    table_v.push_back(mk(0, 0, 0,        0, 0, 0, 0, 14, 0,        0, 0,       1, 1, 'h6004));
    table_v.push_back(mk(1, 0, 0,        0, 0, 0, 0, 14, 0,        0, 0,       0, 0, 0));
    table_v.push_back(mk(1, 0, 0,        0, 0, 0, 0, 13, 0,        0, 0,       0, 0, 0));

    for (int i = 0; i < table_v.size(); i++) begin
      runCycle(table_v[i], 1'b1, $sformatf("vec%0d", i));
    end

    // Three takes after reset, each followed by flush cycles and an mtc0 that clears EXL.
    for (int k = 0; k < 3; k++) begin
      runCycle(mk(1, 8, 32'h0000_0100 + 32'(k * 8), 0, 0, 0, 0, 22, 0, 0, 0, 0, 0, 0), 1'b0, "cnt_take");
      repeat (NFLUSH) runCycle(idle(22), 1'b0, "cnt_flush");
      runCycle(mk(1, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0, 0, 0), 1'b0, "cnt_clr");
    end
    exp_count = COUNT_EN ? 32'd3 : 32'd0;
    applyStimulus(idle(22));
    #2;
    cmp("count_after_3", "cp0_rdata", cp0_rdata, exp_count);
    @(negedge clk);

    for (int i = 0; i < 600; i++) begin
      v.rst_n = ($urandom_range(0, 63) != 0);
      v.exc   = ($urandom_range(0, 3) == 0) ? exc_pool[$urandom_range(0, 4)] : 5'd0;
      v.pc    = $urandom;
      v.bd    = $urandom_range(0, 1) == 1;
      v.eret  = ($urandom_range(0, 7) == 0);
      v.hw    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      v.we    = !v.eret && ($urandom_range(0, 3) == 0);
      v.addr  = addr_pool[$urandom_range(0, 5)];
      v.wdata = ($urandom_range(0, 1) == 1) ? $urandom : (32'($urandom_range(0, 63)) << 10) | 32'($urandom_range(0, 3));
      runCycle(v, 1'b0, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
